mips_run_checker: RTL and testbench

Synthesizable run controller and result checker for the pipelined 32-bit MIPS core. It replaces the fixed clock/reset stimulus with a parametrised sequence: it holds the core in reset for a programmable number of cycles, then runs it. While running it compares each valid `result` word against a loadable table of expected values and stops on the first mismatch, on full match, or on timeout. It sits beside the core in the top level (FPGA self-test) and inside benches as the scoreboard.

---
 rtl/mips_tb_pkg.sv | 18 +
 rtl/mips_run_checker_exp_table.sv | 34 +++
 rtl/mips_run_checker.sv | 162 ++++++++++++++++
 tb/tb_mips_run_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS run controller / result checker.
//   state_e      : run-controller FSM states
//   DEF_*        : default parameter values used by mips_run_checker
package mips_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_NUM_CHK    = 8;
  localparam int unsigned DEF_MAX_CYCLES = 1024;

endpackage

// File: rtl/mips_run_checker_exp_table.sv
// Expected-result register file: NUM_CHK x DATA_W, one synchronous write
// port, one asynchronous read port. Deliberately not reset; contents are
// undefined until written.
//   clk    in  : clock
//   we     in  : write strobe (already qualified by the caller)
//   waddr  in  : write address
//   wdata  in  : write data
//   raddr  in  : read address
//   rdata  out : read data (combinational)
module exp_table #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CHK = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [NUM_CHK];

  // Addresses past NUM_CHK-1 (non power-of-two depth) are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < NUM_CHK)) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mips_run_checker.sv
// Run controller and result checker for the pipelined MIPS core. Holds the
// core in reset for RST_CYCLES, then runs it and compares each valid result
// against the expected table, stopping on mismatch, full match or timeout.
//   clk, rst          : clock, async active-low reset
//   start             : launch / relaunch (IDLE or DONE only)
//   exp_we/addr/data  : expected-table write (IDLE or DONE only)
//   core_rst          : active-high reset to the core
//   result(_valid)    : core result bus
//   busy, done        : status (RESET|RUN, DONE)
//   pass, fail, timeout, err_idx, cycle_count : verdict and diagnostics
module mips_run_checker
  import mips_tb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned NUM_CHK    = DEF_NUM_CHK,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned IDX_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  parameter int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              core_rst,
  input  logic [DATA_W-1:0] result,
  input  logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  err_idx,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

  state_e            r_state, w_state_d;
  logic [RC_W-1:0]   r_rst_cnt, w_rst_cnt_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic [CNT_W-1:0]  r_cycle_count, w_cycle_count_d;
  logic              r_pass, w_pass_d;
  logic              r_fail, w_fail_d;
  logic              r_timeout, w_timeout_d;
  logic              r_core_rst, r_busy, r_done;
  logic              w_idle_or_done;
  logic              w_verdict;
  logic [DATA_W-1:0] w_exp;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);

  exp_table #(
    .DATA_W  (DATA_W),
    .NUM_CHK (NUM_CHK),
    .IDX_W   (IDX_W)
  ) u_exp_table (
    .clk   (clk),
    .we    (exp_we && w_idle_or_done),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (r_idx),
    .rdata (w_exp)
  );

  always_comb begin
    w_state_d       = r_state;
    w_rst_cnt_d     = r_rst_cnt;
    w_idx_d         = r_idx;
    w_cycle_count_d = r_cycle_count;
    w_pass_d        = r_pass;
    w_fail_d        = r_fail;
    w_timeout_d     = r_timeout;
    w_verdict       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_d       = ST_RESET;
          w_rst_cnt_d     = '0;
          w_idx_d         = '0;
          w_cycle_count_d = '0;
          w_pass_d        = 1'b0;
          w_fail_d        = 1'b0;
          w_timeout_d     = 1'b0;
        end
      end
      ST_RESET: begin
        if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          w_state_d       = ST_RUN;
          w_cycle_count_d = CNT_W'(1);  // first RUN cycle reads 1
        end else begin
          w_rst_cnt_d = r_rst_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (result_valid) begin
          if (result == w_exp) begin
            if (r_idx == IDX_W'(NUM_CHK - 1)) begin
              w_verdict = 1'b1;
              w_pass_d  = 1'b1;
            end else begin
              w_idx_d = r_idx + 1'b1;
            end
          end else begin
            w_verdict = 1'b1;
            w_fail_d  = 1'b1;
          end
        end
        // A compare verdict on the last allowed cycle wins over timeout.
        if (w_verdict) begin
          w_state_d = ST_DONE;
        end else if (r_cycle_count == CNT_W'(MAX_CYCLES)) begin
          w_state_d   = ST_DONE;
          w_fail_d    = 1'b1;
          w_timeout_d = 1'b1;
          w_idx_d     = r_idx;
        end else begin
          w_cycle_count_d = r_cycle_count + 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_rst_cnt     <= '0;
      r_idx         <= '0;
      r_cycle_count <= '0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_core_rst    <= 1'b1;  // keep the core in reset while we are
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_rst_cnt     <= w_rst_cnt_d;
      r_idx         <= w_idx_d;
      r_cycle_count <= w_cycle_count_d;
      r_pass        <= w_pass_d;
      r_fail        <= w_fail_d;
      r_timeout     <= w_timeout_d;
      r_core_rst    <= (w_state_d == ST_RESET);
      r_busy        <= (w_state_d == ST_RESET) || (w_state_d == ST_RUN);
      r_done        <= (w_state_d == ST_DONE);
    end
  end

  assign core_rst    = r_core_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign err_idx     = r_idx;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mips_run_checker.sv
module tb_mips_run_checker;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned NUM_CHK    = 4;
  localparam int unsigned MAX_CYCLES = 16;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CNT_W      = 5;

  typedef struct packed {
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [IDX_W-1:0] err_idx;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              core_rst;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [IDX_W-1:0]  err_idx;
  logic [CNT_W-1:0]  cycle_count;

  int   total;
  int   bad;
  int   cur;
  exp_t q[$];
  logic prev_done;

  mips_run_checker #(
    .DATA_W     (DATA_W),
    .RST_CYCLES (RST_CYCLES),
    .NUM_CHK    (NUM_CHK),
    .MAX_CYCLES (MAX_CYCLES),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .exp_we       (exp_we),
    .exp_addr     (exp_addr),
    .exp_data     (exp_data),
    .core_rst     (core_rst),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .err_idx      (err_idx),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: on each rising edge of done, pop the expected verdict.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst && done && !prev_done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got verdict pass=%0d fail=%0d want none", pass, fail);
      end else begin
        e = q.pop_front();
        chk("sb_pass", 32'(pass), 32'(e.pass));
        chk("sb_fail", 32'(fail), 32'(e.fail));
        chk("sb_timeout", 32'(timeout), 32'(e.timeout));
        chk("sb_err_idx", 32'(err_idx), 32'(e.err_idx));
        chk("sb_cycle_count", 32'(cycle_count), 32'(e.cnt));
      end
    end
    prev_done = rst ? done : 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_exp(input int a, input int d);
    exp_we   = 1'b1;
    exp_addr = IDX_W'(a);
    exp_data = DATA_W'(d);
    step();
    exp_we   = 1'b0;
  endtask

  // Pulse start, check restart clears, measure core_rst width; ends in RUN cycle 1.
  task automatic start_run();
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_cycle_count", 32'(cycle_count), 32'd0);
    chk("restart_pass", 32'(pass), 32'd0);
    chk("restart_err_idx", 32'(err_idx), 32'd0);
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      step();
    end
    chk("core_rst_len", 32'(n), RST_CYCLES);
    chk("run_busy", 32'(busy), 32'd1);
    cur = 1;
  endtask

  // Present value so it is sampled while cycle_count == target.
  task automatic drive_at(input int target, input int value);
    while (cur < target) begin
      step();
      cur++;
    end
    result_valid = 1'b1;
    result       = DATA_W'(value);
    step();
    cur++;
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      n++;
      step();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got done=0 want done=1 within %0d cycles", limit);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cur = 0;
    rst = 1'b0;
    start = 1'b0;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    result = '0;
    result_valid = 1'b0;

    step();
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({pass, fail, timeout}), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_core_rst", 32'(core_rst), 32'd0);

    write_exp(0, 5);
    write_exp(1, 10);
    write_exp(2, 15);
    write_exp(3, 20);

    // Full pass with gaps.
    q.push_back('{pass: 1'b1, fail: 1'b0, timeout: 1'b0, err_idx: 2'd3, cnt: 5'd7});
    start_run();
    drive_at(1, 5);
    drive_at(3, 10);
    drive_at(6, 15);
    drive_at(7, 20);
    chk("pass_latency", 32'(done), 32'd1);
    step();
    step();

    // Mismatch on entry 1.
    q.push_back('{pass: 1'b0, fail: 1'b1, timeout: 1'b0, err_idx: 2'd1, cnt: 5'd2});
    start_run();
    drive_at(1, 5);
    drive_at(2, 11);
    chk("fail_latency", 32'(done), 32'd1);
    step();
    step();

    // Timeout after one match.
    q.push_back('{pass: 1'b0, fail: 1'b1, timeout: 1'b1, err_idx: 2'd1, cnt: 5'd16});
    start_run();
    drive_at(1, 5);
    wait_done(30);
    step();
    step();

    // Final match exactly on the MAX_CYCLES cycle.
    q.push_back('{pass: 1'b1, fail: 1'b0, timeout: 1'b0, err_idx: 2'd3, cnt: 5'd16});
    start_run();
    drive_at(1, 5);
    drive_at(2, 10);
    drive_at(3, 15);
    drive_at(16, 20);
    chk("edge_latency", 32'(done), 32'd1);
    step();
    step();

    // start and exp_we during RUN are ignored.
    q.push_back('{pass: 1'b1, fail: 1'b0, timeout: 1'b0, err_idx: 2'd3, cnt: 5'd5});
    start_run();
    drive_at(1, 5);
    start    = 1'b1;
    exp_we   = 1'b1;
    exp_addr = 2'd0;
    exp_data = 32'd99;
    step();
    cur++;
    start  = 1'b0;
    exp_we = 1'b0;
    chk("ignore_start_core_rst", 32'(core_rst), 32'd0);
    drive_at(3, 10);
    drive_at(4, 15);
    drive_at(5, 20);
    step();
    step();

    // Rewrite entry 1 in DONE and relaunch; entry 0 must still be 5.
    write_exp(1, 11);
    q.push_back('{pass: 1'b1, fail: 1'b0, timeout: 1'b0, err_idx: 2'd3, cnt: 5'd4});
    start_run();
    drive_at(1, 5);
    drive_at(2, 11);
    drive_at(3, 15);
    drive_at(4, 20);
    step();
    step();

    // Asynchronous reset mid-RUN.
    start_run();
    drive_at(1, 5);
    drive_at(2, 11);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_cycle_count", 32'(cycle_count), 32'd0);
    chk("midrst_verdict", 32'({done, pass, fail, timeout}), 32'd0);
    #3;
    rst = 1'b1;
    step();
    chk("postrst_core_rst", 32'(core_rst), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);

    step();
    chk("pending_verdicts", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
